// File: rtl/tmon_responder.sv
// tmon_responder: responder for the temperature-monitor command bus.
// Executes configuration commands, requests periodic sensor samples,
// registers the latest reading and drives a hysteretic over-temperature alarm.
module tmon_responder #(
    parameter logic [7:0]  DEFAULT_FRQ    = 8'd10,
    parameter logic [7:0]  DEFAULT_HIGH   = 8'd80,
    parameter logic [7:0]  HYST           = 8'd2,
    parameter int unsigned SAMPLE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [2:0] op,
    input  logic [7:0] opnd,
    output logic       op_ready,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic       sample_req,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    output logic       sample_err,
    output logic [7:0] temp_out,
    output logic [7:0] high_temp,
    output logic [7:0] freq,
    output logic       alarm
);

    localparam int unsigned   TW     = $clog2(SAMPLE_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_TIMEOUT - 1);

    localparam logic [2:0] OP_RESET    = 3'd1;
    localparam logic [2:0] OP_SET_FRQ  = 3'd2;
    localparam logic [2:0] OP_SET_HIGH = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_EXEC        = 2'd1,
        S_SAMPLE_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [7:0]    opnd_q, opnd_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic          op_ready_d;
    logic          cmd_done_d;
    logic          cmd_err_d;
    logic          sample_req_d;
    logic          sample_err_d;
    logic [7:0]    temp_d;
    logic [7:0]    high_d;
    logic [7:0]    freq_d;
    logic          alarm_d;

    logic          accept;
    logic          expire;
    logic [7:0]    clr;

    // Next-state, register updates and output pulses for the coming edge.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        opnd_d       = opnd_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        tcnt_d       = tcnt_q;
        op_ready_d   = 1'b0;
        cmd_done_d   = 1'b0;
        cmd_err_d    = 1'b0;
        sample_req_d = 1'b0;
        sample_err_d = 1'b0;
        temp_d       = temp_out;
        high_d       = high_temp;
        freq_d       = freq;
        alarm_d      = alarm;

        clr    = (high_temp >= HYST) ? (high_temp - HYST) : 8'd0;
        accept = op_valid && op_ready;
        expire = (freq != 8'd0) && (cnt_q == (freq - 8'd1));

        // Free-running period counter; an expiry arms a single pending sample.
        if (freq == 8'd0) begin
            cnt_d = 8'd0;
        end else if (expire) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        if (expire) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Command wins over a pending sample; the sample follows EXEC.
                    state_d      = S_EXEC;
                    op_d         = op;
                    opnd_d       = opnd;
                    cmd_done_d   = 1'b1;
                    cmd_err_d    = (op > OP_SET_HIGH);
                    sample_req_d = pend_d && (op != OP_RESET);
                end else if (pend_q) begin
                    state_d      = S_SAMPLE_WAIT;
                    pend_d       = 1'b0;
                    tcnt_d       = '0;
                    sample_req_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_RESET: begin
                        freq_d  = DEFAULT_FRQ;
                        high_d  = DEFAULT_HIGH;
                        temp_d  = 8'd0;
                        alarm_d = 1'b0;
                        cnt_d   = 8'd0;
                        pend_d  = 1'b0;
                    end
                    OP_SET_FRQ: begin
                        freq_d = opnd_q;
                        cnt_d  = 8'd0;
                        pend_d = pend_q;
                    end
                    OP_SET_HIGH: begin
                        high_d = opnd_q;
                    end
                    default: begin
                        // NOOP and illegal opcodes leave the registers alone.
                    end
                endcase
                if (pend_q && (op_q != OP_RESET)) begin
                    state_d = S_SAMPLE_WAIT;
                    pend_d  = 1'b0;
                    tcnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SAMPLE_WAIT: begin
                if (sample_valid) begin
                    temp_d  = sample_data;
                    state_d = S_IDLE;
                    if (sample_data > high_temp) begin
                        alarm_d = 1'b1;
                    end else if (sample_data <= clr) begin
                        alarm_d = 1'b0;
                    end
                end else if (tcnt_q == T_LAST) begin
                    sample_err_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        op_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset returns everything to defaults.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= 3'd0;
            opnd_q     <= 8'd0;
            cnt_q      <= 8'd0;
            pend_q     <= 1'b0;
            tcnt_q     <= '0;
            op_ready   <= 1'b1;
            cmd_done   <= 1'b0;
            cmd_err    <= 1'b0;
            sample_req <= 1'b0;
            sample_err <= 1'b0;
            temp_out   <= 8'd0;
            high_temp  <= DEFAULT_HIGH;
            freq       <= DEFAULT_FRQ;
            alarm      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            tcnt_q     <= tcnt_d;
            op_ready   <= op_ready_d;
            cmd_done   <= cmd_done_d;
            cmd_err    <= cmd_err_d;
            sample_req <= sample_req_d;
            sample_err <= sample_err_d;
            temp_out   <= temp_d;
            high_temp  <= high_d;
            freq       <= freq_d;
            alarm      <= alarm_d;
        end
    end

endmodule

// File: doc/tmon_responder.md
Name: tmon_responder

Overview:
- Responder end of the temperature-monitor command bus. Accepts op/opnd commands via a valid/ready handshake and holds the sampling-period and high-temperature registers.
- Periodically requests a sample from the sensor front-end, registers the reading, and drives a hysteretic over-temperature alarm.
- Sits between the bus master and the sensor interface.

Parameters:
- DEFAULT_FRQ, 8'd10, sampling period in clk cycles after reset or RESET op; 0 disables sampling.
- DEFAULT_HIGH, 8'd80, high-temperature threshold after reset or RESET op.
- HYST, 8'd2, alarm clear hysteresis.
- SAMPLE_TIMEOUT, 16, cycles to wait for sample_valid before aborting.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  command present on op/opnd
- op  in  3  opcode: NOOP=0, RESET=1, SET_FRQ=2, SET_HIGH_TEMP=3, others illegal
- opnd  in  8  command operand
- op_ready  out  1  responder can accept a command this cycle
- cmd_done  out  1  one-cycle pulse: command executed
- cmd_err  out  1  one-cycle pulse: illegal opcode executed
- sample_req  out  1  one-cycle pulse requesting a sensor sample
- sample_valid  in  1  sensor data valid
- sample_data  in  8  unsigned sensor reading
- sample_err  out  1  one-cycle pulse: sample timeout
- temp_out  out  8  last valid sample
- high_temp  out  8  current threshold
- freq  out  8  current sampling period
- alarm  out  1  over-temperature flag

Behaviour:
- Reset (async):
  - State=IDLE, op_ready=1, all pulses 0, temp_out=0, alarm=0.
  - freq=DEFAULT_FRQ, high_temp=DEFAULT_HIGH, period counter=0, pending=0.
- States: IDLE, EXEC, SAMPLE_WAIT. op_ready=1 only in IDLE.
- IDLE, command handling:
  - op_valid&&op_ready is an accept: latch op/opnd, go to EXEC.
  - op/opnd are ignored when not accepted.
- EXEC (exactly 1 cycle), by latched op:
  - NOOP: no register change.
  - SET_FRQ: freq<=opnd; period counter<=0.
  - SET_HIGH_TEMP: high_temp<=opnd.
  - RESET: freq, high_temp, temp_out, alarm, counter and pending take their reset values.
  - Illegal opcode: no register change; cmd_err=1 this cycle.
  - cmd_done=1 in EXEC for every op, legal or not.
  - Next state: SAMPLE_WAIT if pending (sample_req=1 on entry), else IDLE.
  - Accept-to-cmd_done latency is 1 cycle; back-to-back commands are accepted at most every 2 cycles.
- Period counter:
  - Runs in all states when freq!=0; holds at 0 when freq==0.
  - Increments each cycle. When counter==freq-1, it wraps to 0 and sets pending.
- Sampling:
  - In IDLE with pending set and no accept this cycle: clear pending, pulse sample_req, go to SAMPLE_WAIT.
  - An accept and pending in the same IDLE cycle: the command wins and pending is kept.
  - Expiries while pending is already set are dropped (no queueing beyond 1).
- SAMPLE_WAIT:
  - Timeout counter starts at 0 on entry.
  - sample_valid=1: temp_out<=sample_data, go to IDLE.
  - Timeout counter reaches SAMPLE_TIMEOUT-1 without sample_valid: sample_err=1, temp_out and alarm unchanged, go to IDLE.
  - sample_valid outside SAMPLE_WAIT is ignored.
- Alarm, evaluated on each valid sample s:
  - s>high_temp: alarm<=1.
  - s<=clr, where clr=high_temp-HYST saturating at 0: alarm<=0.
  - Otherwise alarm holds.
  - Changing high_temp does not re-evaluate alarm until the next sample.
- Unsigned 8-bit arithmetic throughout; no wrap in threshold compare.
- Reset asserted mid-command or mid-sample aborts immediately to reset values; no pulses are emitted.

Test Plan:
- Reset, then freq=0 via SET_FRQ opnd=0 -> op_ready=1, freq=0, no sample_req for 100 cycles; cmd_done pulses exactly 1 cycle after accept.
- SET_FRQ opnd=5, sensor replies 1 cycle after each req with 8'd50 -> sample_req every 5 cycles, temp_out=50, alarm=0.
- SET_HIGH_TEMP 60, then samples 61, 59, 58 with HYST=2 -> alarm 1, stays 1, clears on 58.
- op=5 -> cmd_err and cmd_done pulse together, freq and high_temp unchanged; RESET op after alarm=1 -> freq=10, high_temp=80, alarm=0, temp_out=0.
- Sensor never answers -> sample_err after 16 cycles in SAMPLE_WAIT, op_ready low during the wait, temp_out unchanged.
- Command valid in the same cycle as period expiry -> command executes first, sample_req pulses in the EXEC cycle; async reset in SAMPLE_WAIT -> immediate IDLE and defaults.
